// File: rtl/argmax_classifier_if.sv
// Handshake bundle between the softmax stage, the argmax classifier and its consumer.
interface argmax_classifier_if #(
  parameter int N_CLASSES = 10,
  parameter int DW        = 16
);
  logic [N_CLASSES*DW-1:0] prob_in;
  logic                    in_valid;
  logic                    busy;
  logic [3:0]              class_id;
  logic [DW-1:0]           class_prob;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;
  logic                    low_conf;

  modport master (
    output prob_in, in_valid, out_ready,
    input  busy, class_id, class_prob, out_valid, overrun, low_conf
  );

  modport slave (
    input  prob_in, in_valid, out_ready,
    output busy, class_id, class_prob, out_valid, overrun, low_conf
  );
endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over a captured probability vector, one entry per cycle.
// Optional macro ARGMAX_THRESH_EN builds the low-confidence comparator on the result.
module argmax_classifier #(
  parameter int            N_CLASSES   = 10,
  parameter int            DW          = 16,
  parameter logic [DW-1:0] CONF_THRESH = 16'h2000
) (
  input logic                clk,
  input logic                rst,
  argmax_classifier_if.slave bus
);

  localparam int             IW       = $clog2(N_CLASSES + 1);
  localparam logic [IW-1:0]  LOAD_IDX = IW'(N_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N_CLASSES*DW-1:0] r_cap;
  logic [IW-1:0]           r_idx;
  logic [DW-1:0]           r_best;
  logic [IW-1:0]           r_best_idx;
  logic                    r_busy;
  logic                    r_out_valid;
  logic [3:0]              r_class_id;
  logic [DW-1:0]           r_class_prob;
  logic                    r_overrun;

  logic [IW-1:0]           w_sel;
  logic [DW-1:0]           w_entry;
  logic                    w_capture;
  logic                    w_examine;
  logic                    w_load;
  logic                    w_release;
  logic                    w_drop;

  // The counter overshoots to N_CLASSES for the load cycle; keep the select in range there.
  assign w_sel   = (r_idx < LOAD_IDX) ? r_idx : {IW{1'b0}};
  assign w_entry = r_cap[int'(w_sel)*DW +: DW];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = SCAN;
        else              w_state_nxt = IDLE;
      end
      SCAN: begin
        if (r_idx == LOAD_IDX) w_state_nxt = HOLD;
        else                   w_state_nxt = SCAN;
      end
      HOLD: begin
        if (bus.out_ready && bus.in_valid) w_state_nxt = SCAN;
        else if (bus.out_ready)            w_state_nxt = IDLE;
        else                               w_state_nxt = HOLD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state strobes steering the datapath
  always_comb begin
    w_capture = 1'b0;
    w_examine = 1'b0;
    w_load    = 1'b0;
    w_release = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      IDLE: begin
        w_capture = bus.in_valid;
      end
      SCAN: begin
        if (r_idx == LOAD_IDX) w_load = 1'b1;
        else                   w_examine = 1'b1;
        w_drop = bus.in_valid;
      end
      HOLD: begin
        w_release = bus.out_ready;
        w_capture = bus.out_ready & bus.in_valid;
        w_drop    = ~bus.out_ready & bus.in_valid;
      end
      default: begin
        w_capture = 1'b0;
      end
    endcase
  end

  // Capture register, scan counter and running best
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cap      <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
    end else if (w_capture) begin
      r_cap <= bus.prob_in;
      r_idx <= '0;
    end else if (w_examine) begin
      r_idx <= r_idx + IW'(1);
      // Strict compare keeps the lowest index on ties.
      if ((r_idx == {IW{1'b0}}) || (w_entry > r_best)) begin
        r_best     <= w_entry;
        r_best_idx <= r_idx;
      end
    end
  end

  // Registered result, handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_class_id   <= 4'd0;
      r_class_prob <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != IDLE);
      r_overrun <= r_overrun | w_drop;
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_class_id   <= 4'(r_best_idx);
        r_class_prob <= r_best;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ARGMAX_THRESH_EN
  logic r_low_conf;

  // Confidence flag loaded alongside the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_low_conf <= 1'b0;
    end else if (w_load) begin
      r_low_conf <= (r_best < CONF_THRESH);
    end
  end

  assign bus.low_conf = r_low_conf;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^CONF_THRESH;
  assign bus.low_conf    = 1'b0;
`endif

  assign bus.busy       = r_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.class_id   = r_class_id;
  assign bus.class_prob = r_class_prob;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: latency, tie rule, hold/overrun, back-to-back, reset abort.
module tb_argmax_classifier;
  localparam int N  = 10;
  localparam int DW = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef ARGMAX_THRESH_EN
  localparam logic EXP_LOWCONF_CCC = 1'b1;
`else
  localparam logic EXP_LOWCONF_CCC = 1'b0;
`endif

  argmax_classifier_if #(.N_CLASSES(N), .DW(DW)) u_if ();

  argmax_classifier #(.N_CLASSES(N), .DW(DW), .CONF_THRESH(16'h2000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", u_if.busy); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd0) begin errors++; $display("FAIL reset_id got %0d want 0", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h0000) begin errors++; $display("FAIL reset_prob got %h want 0000", u_if.class_prob); end
    checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", u_if.overrun); end
    checks++; if (u_if.low_conf !== 1'b0) begin errors++; $display("FAIL reset_lowconf got %0b want 0", u_if.low_conf); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N*DW-1:0] v;
    v = {N{16'h0400}};
    v[7*DW +: DW] = 16'h6000;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.prob_in = {N{16'hFFFF}};
    checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", u_if.busy); end
    repeat (10) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid at edge 10 got %0b want 0", u_if.out_valid); end
    @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid at edge 11 got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd7) begin errors++; $display("FAIL basic_id got %0d want 7", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h6000) begin errors++; $display("FAIL basic_prob got %h want 6000", u_if.class_prob); end
    checks++; if (u_if.low_conf !== 1'b0) begin errors++; $display("FAIL basic_lowconf got %0b want 0", u_if.low_conf); end
    @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_release_valid got %0b want 0", u_if.out_valid); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL basic_release_busy got %0b want 0", u_if.busy); end
  endtask

  task automatic test_tie();
    logic [N*DW-1:0] v;
    v = {N{16'h0100}};
    v[2*DW +: DW] = 16'h3000;
    v[5*DW +: DW] = 16'h3000;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd2) begin errors++; $display("FAIL tie_id got %0d want 2", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h3000) begin errors++; $display("FAIL tie_prob got %h want 3000", u_if.class_prob); end
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    u_if.prob_in = '0; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd0) begin errors++; $display("FAIL zero_id got %0d want 0", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h0000) begin errors++; $display("FAIL zero_prob got %h want 0000", u_if.class_prob); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N*DW-1:0] v;
    v = {N{16'h0200}};
    v[4*DW +: DW] = 16'h4000;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b0;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (u_if.class_id !== 4'd4) begin errors++; $display("FAIL b2b_first_id got %0d want 4", u_if.class_id); end
    v = {N{16'h0100}};
    v[9*DW +: DW] = 16'h7000;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid got %0b want 0", u_if.out_valid); end
    checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b want 1", u_if.busy); end
    checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %0b want 0", u_if.overrun); end
    repeat (10) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got %0b want 0", u_if.out_valid); end
    @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd9) begin errors++; $display("FAIL b2b_id got %0d want 9", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h7000) begin errors++; $display("FAIL b2b_prob got %h want 7000", u_if.class_prob); end
    u_if.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_drop();
    logic [N*DW-1:0] v;
    v = {N{16'h0111}};
    v[6*DW +: DW] = 16'h3333;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    v = {N{16'h0000}};
    v[1*DW +: DW] = 16'h7FFF;
    u_if.prob_in = v; u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    checks++; if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL scan_overrun got %0b want 1", u_if.overrun); end
    repeat (7) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL scan_valid got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd6) begin errors++; $display("FAIL scan_id got %0d want 6", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h3333) begin errors++; $display("FAIL scan_prob got %h want 3333", u_if.class_prob); end
    @(negedge clk);
  endtask

  task automatic test_hold_overrun();
    logic [N*DW-1:0] v;
    logic            bad;
    v = {N{16'h1000}};
    v[3*DW +: DW] = 16'h5000;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b0;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (u_if.class_id !== 4'd3) begin errors++; $display("FAIL hold_id got %0d want 3", u_if.class_id); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b1 || u_if.class_id !== 4'd3 || u_if.class_prob !== 16'h5000) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_stable got unstable outputs want valid=1 id=3 prob=5000"); end
    v = {N{16'h0000}};
    v[0*DW +: DW] = 16'h7FFF;
    u_if.prob_in = v; u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    checks++; if (u_if.class_id !== 4'd3) begin errors++; $display("FAIL hold_drop_id got %0d want 3", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h5000) begin errors++; $display("FAIL hold_drop_prob got %h want 5000", u_if.class_prob); end
    checks++; if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL hold_overrun got %0b want 1", u_if.overrun); end
    u_if.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got %0b want 0", u_if.out_valid); end
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL hold_release_busy got %0b want 0", u_if.busy); end
    checks++; if (u_if.overrun !== 1'b1) begin errors++; $display("FAIL hold_sticky_overrun got %0b want 1", u_if.overrun); end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL hold_dropped_result got out_valid=1 want 0"); end
  endtask

  task automatic test_low_conf();
    u_if.prob_in = {N{16'h0CCC}}; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (u_if.class_id !== 4'd0) begin errors++; $display("FAIL lowconf_id got %0d want 0", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h0CCC) begin errors++; $display("FAIL lowconf_prob got %h want 0ccc", u_if.class_prob); end
    checks++; if (u_if.low_conf !== EXP_LOWCONF_CCC) begin errors++; $display("FAIL lowconf_flag got %0b want %0b", u_if.low_conf, EXP_LOWCONF_CCC); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [N*DW-1:0] v;
    logic            bad;
    v = {N{16'h0100}};
    v[8*DW +: DW] = 16'h6666;
    u_if.prob_in = v; u_if.in_valid = 1'b1; u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", u_if.busy); end
    checks++; if (u_if.class_prob !== 16'h0000) begin errors++; $display("FAIL abort_prob got %h want 0000", u_if.class_prob); end
    checks++; if (u_if.overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun got %0b want 0", u_if.overrun); end
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0b want 0", u_if.out_valid); end
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b0 || u_if.busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL abort_no_result got activity want idle"); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; u_if.in_valid = 1'b1;
    @(negedge clk);
    u_if.in_valid = 1'b0;
    checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL first_edge_busy got %0b want 1", u_if.busy); end
    repeat (10) @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b0) begin errors++; $display("FAIL first_edge_early got %0b want 0", u_if.out_valid); end
    @(negedge clk);
    checks++; if (u_if.out_valid !== 1'b1) begin errors++; $display("FAIL first_edge_valid got %0b want 1", u_if.out_valid); end
    checks++; if (u_if.class_id !== 4'd8) begin errors++; $display("FAIL first_edge_id got %0d want 8", u_if.class_id); end
    checks++; if (u_if.class_prob !== 16'h6666) begin errors++; $display("FAIL first_edge_prob got %h want 6666", u_if.class_prob); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    u_if.prob_in = '0;
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie();
    test_all_zero();
    test_back_to_back();
    test_scan_drop();
    test_hold_overrun();
    test_low_conf();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
